// File: rtl/video_capture.sv
// video_capture: rebuilds 7-dot Apple II/e video cells from the serial VIDEO stream and queues them.
// Latency: a word appears on PIX_* from the load-tick edge that completes it (the FIFO has no bypass).
// Backpressure: 4-entry valid/ready FIFO; a word arriving while full is dropped and OVF latches.
// Ports: CLK_14M/reset (synchronous, active-high); CLK_7M, LDPS_N, WNDW_N, VIDEO follow generator timing;
//        PIX_DATA/PIX_COL/PIX_VALID/PIX_READY carry the word stream; OVF/BITERR are sticky error flags.
module video_capture #(
   parameter int FIFO_AW = 2,
   parameter int COL_W   = 6
) (
   input  logic             CLK_14M,
   input  logic             reset,
   input  logic             CLK_7M,
   input  logic             LDPS_N,
   input  logic             WNDW_N,
   input  logic             VIDEO,
   output logic [6:0]       PIX_DATA,
   output logic [COL_W-1:0] PIX_COL,
   output logic             PIX_VALID,
   input  logic             PIX_READY,
   output logic             OVF,
   output logic             BITERR
);
   localparam int               DEPTH  = 1 << FIFO_AW;
   localparam int               EW     = COL_W + 7;
   localparam logic [FIFO_AW:0] C_FULL = DEPTH[FIFO_AW:0];

   // capture state
   logic [6:0]       r_acc;
   logic [3:0]       r_cnt;
   logic             r_armed;
   logic             r_wlat;
   logic [COL_W-1:0] r_col;

   // fifo state
   logic [EW-1:0]      r_mem [DEPTH];
   logic [FIFO_AW-1:0] r_wp;
   logic [FIFO_AW-1:0] r_rp;
   logic [FIFO_AW:0]   r_count;

   logic r_ovf;
   logic r_biterr;

   logic          w_dot;
   logic          w_load;
   logic          w_push;
   logic          w_pop;
   logic          w_full;
   logic          w_wr;
   logic [6:0]    w_acc;
   logic [3:0]    w_cnt;
   logic [EW-1:0] w_head;

   assign w_dot  = ~CLK_7M;
   assign w_load = w_dot & ~LDPS_N;

   // The dot sampled on a load tick still belongs to the outgoing word, so the
   // pushed word and its dot count are taken from the post-sample values.
   always_comb begin
      w_acc = r_acc;
      if (r_cnt < 4'd7) begin
         w_acc[r_cnt[2:0]] = VIDEO;
      end
   end

   assign w_cnt  = (r_cnt == 4'd8) ? 4'd8 : r_cnt + 4'd1;

   // The window latch holds WNDW_N from the load that started this word.
   assign w_push = w_load & r_armed & ~r_wlat;

   assign w_full = (r_count == C_FULL);
   assign w_pop  = PIX_VALID & PIX_READY;
   // a full FIFO still accepts a word when the head leaves on the same edge
   assign w_wr   = w_push & (~w_full | w_pop);

   always_ff @(posedge CLK_14M) begin
      if (reset) begin
         r_acc   <= '0;
         r_cnt   <= '0;
         r_armed <= 1'b0;
         r_wlat  <= 1'b1;
         r_col   <= '0;
      end else if (w_dot) begin
         if (w_load) begin
            if (w_push) begin
               r_col <= r_col + COL_W'(1);
            end
            // blanking restarts the line; overrides the increment above
            if (WNDW_N) begin
               r_col <= '0;
            end
            r_wlat  <= WNDW_N;
            r_acc   <= '0;
            r_cnt   <= '0;
            r_armed <= 1'b1;
         end else begin
            r_acc <= w_acc;
            r_cnt <= w_cnt;
         end
      end
   end

   always_ff @(posedge CLK_14M) begin
      if (reset) begin
         r_ovf    <= 1'b0;
         r_biterr <= 1'b0;
      end else begin
         if (w_push && w_full && !w_pop) begin
            r_ovf <= 1'b1;
         end
         if (w_push && (w_cnt != 4'd7)) begin
            r_biterr <= 1'b1;
         end
      end
   end

   always_ff @(posedge CLK_14M) begin
      if (reset) begin
         r_wp    <= '0;
         r_rp    <= '0;
         r_count <= '0;
      end else begin
         if (w_wr) begin
            r_wp <= r_wp + FIFO_AW'(1);
         end
         if (w_pop) begin
            r_rp <= r_rp + FIFO_AW'(1);
         end
         case ({w_wr, w_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

   // storage needs no reset: entries are only visible below r_count
   always_ff @(posedge CLK_14M) begin
      if (w_wr) begin
         r_mem[r_wp] <= {r_col, w_acc};
      end
   end

   assign w_head    = r_mem[r_rp];
   assign PIX_VALID = (r_count != '0);
   assign PIX_DATA  = PIX_VALID ? w_head[6:0]    : 7'd0;
   assign PIX_COL   = PIX_VALID ? w_head[EW-1:7] : '0;
   assign OVF       = r_ovf;
   assign BITERR    = r_biterr;

endmodule

// File: tb/tb_video_capture.sv
// tb_video_capture: directed bench for video_capture; drives generator-style dot timing.
// Inputs change on CLK_14M falling edges; outputs are read at falling edges.
// Popped words are collected by a monitor and compared against hand-computed tables.
module tb_video_capture;
   localparam int COL_W = 6;

   logic             CLK_14M = 1'b0;
   logic             reset;
   logic             CLK_7M;
   logic             LDPS_N;
   logic             WNDW_N;
   logic             VIDEO;
   logic [6:0]       PIX_DATA;
   logic [COL_W-1:0] PIX_COL;
   logic             PIX_VALID;
   logic             PIX_READY;
   logic             OVF;
   logic             BITERR;

   int          n_chk = 0;
   int          n_err = 0;
   logic [31:0] cap_q [$];

   video_capture #(.FIFO_AW(2), .COL_W(COL_W)) dut (
      .CLK_14M   (CLK_14M),
      .reset     (reset),
      .CLK_7M    (CLK_7M),
      .LDPS_N    (LDPS_N),
      .WNDW_N    (WNDW_N),
      .VIDEO     (VIDEO),
      .PIX_DATA  (PIX_DATA),
      .PIX_COL   (PIX_COL),
      .PIX_VALID (PIX_VALID),
      .PIX_READY (PIX_READY),
      .OVF       (OVF),
      .BITERR    (BITERR)
   );

   always #5 CLK_14M = ~CLK_14M;

   // record every word that will be popped on the next rising edge
   always @(negedge CLK_14M) begin
      #2;
      if (PIX_VALID && PIX_READY) begin
         cap_q.push_back({19'd0, PIX_COL, PIX_DATA});
      end
   end

   initial begin
      #3000000;
      $display("FAIL watchdog: simulation did not reach the end");
      $fatal(1);
   end

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
      end
   endtask

   function automatic logic [31:0] ent(input int i);
      return (i < cap_q.size()) ? cap_q[i] : 32'hFFFF_FFFF;
   endfunction

   function automatic logic [31:0] exp_e(input int c, input int d);
      return 32'(((c & 63) << 7) | (d & 127));
   endfunction

   // one 7M period: a dot-tick edge followed by a non-dot edge
   task automatic dot(input logic v, input logic ld, input logic w, input logic pulse);
      @(negedge CLK_14M);
      CLK_7M = 1'b0;
      VIDEO  = v;
      LDPS_N = ld;
      WNDW_N = w;
      if (pulse) PIX_READY = 1'b1;
      @(negedge CLK_14M);
      CLK_7M = 1'b1;
      LDPS_N = 1'b1;
      if (pulse) PIX_READY = 1'b0;
   endtask

   // n dots LSB-first, LDPS_N low on the last; dots past the seventh are lit
   task automatic send_word(input logic [6:0] d, input int n, input logic w, input logic pulse);
      for (int i = 0; i < n; i++) begin
         dot((i < 7) ? d[i] : 1'b1, (i == n - 1) ? 1'b0 : 1'b1, w, pulse && (i == n - 1));
      end
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge CLK_14M);
   endtask

   initial begin
      reset = 1'b1; CLK_7M = 1'b1; LDPS_N = 1'b1; WNDW_N = 1'b1; VIDEO = 1'b0; PIX_READY = 1'b0;
      idle(3);
      chk("rst_valid", 32'(PIX_VALID), 32'd0);
      chk("rst_data",  32'(PIX_DATA),  32'd0);
      chk("rst_col",   32'(PIX_COL),   32'd0);
      chk("rst_ovf",   32'(OVF),       32'd0);
      chk("rst_biterr", 32'(BITERR),   32'd0);
      reset = 1'b0;
      PIX_READY = 1'b1;

      // steady-state capture: first load only arms
      send_word(7'h00, 7, 1'b0, 1'b0);
      chk("arm_no_push", 32'(PIX_VALID), 32'd0);
      send_word(7'h55, 7, 1'b0, 1'b0);
      chk("t1_valid", 32'(PIX_VALID), 32'd1);
      chk("t1_head",  {19'd0, PIX_COL, PIX_DATA}, exp_e(0, 'h55));
      send_word(7'h2A, 7, 1'b0, 1'b0);
      send_word(7'h7F, 7, 1'b0, 1'b0);
      idle(4);
      chk("t1_count", 32'(cap_q.size()), 32'd3);
      chk("t1_w0", ent(0), exp_e(0, 'h55));
      chk("t1_w1", ent(1), exp_e(1, 'h2A));
      chk("t1_w2", ent(2), exp_e(2, 'h7F));
      chk("t1_ovf", 32'(OVF), 32'd0);
      chk("t1_biterr", 32'(BITERR), 32'd0);
      cap_q.delete();

      // window: the word closed by the first blank load is still active (col 3)
      repeat (3) send_word(7'h00, 7, 1'b1, 1'b0);
      idle(4);
      chk("t2_blank_count", 32'(cap_q.size()), 32'd1);
      chk("t2_last_active", ent(0), exp_e(3, 0));
      cap_q.delete();
      send_word(7'h00, 7, 1'b0, 1'b0);
      for (int j = 0; j < 40; j++) send_word(7'(j + 16), 7, (j == 39), 1'b0);
      send_word(7'h00, 7, 1'b1, 1'b0);
      idle(4);
      chk("t2_line_count", 32'(cap_q.size()), 32'd40);
      for (int j = 0; j < 40; j++) chk($sformatf("t2_line_w%0d", j), ent(j), exp_e(j, j + 16));
      cap_q.delete();
      send_word(7'h00, 7, 1'b0, 1'b0);
      send_word(7'h33, 7, 1'b0, 1'b0);
      idle(4);
      chk("t2_restart_count", 32'(cap_q.size()), 32'd1);
      chk("t2_restart_w0", ent(0), exp_e(0, 'h33));
      cap_q.delete();

      // simultaneous push/pop while full
      send_word(7'h00, 7, 1'b1, 1'b0);
      send_word(7'h00, 7, 1'b0, 1'b0);
      idle(4);
      cap_q.delete();
      PIX_READY = 1'b0;
      for (int j = 0; j < 4; j++) send_word(7'(16 + j), 7, 1'b0, 1'b0);
      chk("t4_full_head", {19'd0, PIX_COL, PIX_DATA}, exp_e(0, 'h10));
      send_word(7'h14, 7, 1'b0, 1'b1);
      chk("t4_ovf", 32'(OVF), 32'd0);
      chk("t4_valid", 32'(PIX_VALID), 32'd1);
      chk("t4_new_head", {19'd0, PIX_COL, PIX_DATA}, exp_e(1, 'h11));
      chk("t4_popped", ent(0), exp_e(0, 'h10));
      PIX_READY = 1'b1;
      idle(10);
      chk("t4_count", 32'(cap_q.size()), 32'd5);
      for (int k = 1; k < 5; k++) chk($sformatf("t4_w%0d", k), ent(k), exp_e(k, 16 + k));
      cap_q.delete();

      // backpressure and overflow
      send_word(7'h00, 7, 1'b1, 1'b0);
      send_word(7'h00, 7, 1'b0, 1'b0);
      idle(4);
      cap_q.delete();
      PIX_READY = 1'b0;
      for (int j = 0; j < 6; j++) begin
         send_word(7'(64 + j), 7, 1'b0, 1'b0);
         if (j == 0) chk("t3_head_first", {19'd0, PIX_COL, PIX_DATA}, exp_e(0, 'h40));
         if (j == 3) chk("t3_ovf_at_full", 32'(OVF), 32'd0);
         if (j == 4) chk("t3_ovf_drop", 32'(OVF), 32'd1);
      end
      chk("t3_head_held", {19'd0, PIX_COL, PIX_DATA}, exp_e(0, 'h40));
      chk("t3_valid", 32'(PIX_VALID), 32'd1);
      PIX_READY = 1'b1;
      idle(10);
      chk("t3_count", 32'(cap_q.size()), 32'd4);
      for (int k = 0; k < 4; k++) chk($sformatf("t3_w%0d", k), ent(k), exp_e(k, 64 + k));
      chk("t3_ovf_sticky", 32'(OVF), 32'd1);
      cap_q.delete();

      // runt and long words (column continues at 6)
      chk("t5_biterr_pre", 32'(BITERR), 32'd0);
      send_word(7'h7F, 5, 1'b0, 1'b0);
      chk("t5_biterr_runt", 32'(BITERR), 32'd1);
      send_word(7'h2B, 9, 1'b0, 1'b0);
      send_word(7'h11, 7, 1'b0, 1'b0);
      idle(4);
      chk("t5_biterr_sticky", 32'(BITERR), 32'd1);
      chk("t5_count", 32'(cap_q.size()), 32'd3);
      chk("t5_runt", ent(0), exp_e(6, 'h1F));
      chk("t5_long", ent(1), exp_e(7, 'h2B));
      chk("t5_normal", ent(2), exp_e(8, 'h11));
      cap_q.delete();

      // reset mid-word with two entries queued
      PIX_READY = 1'b0;
      send_word(7'h21, 7, 1'b0, 1'b0);
      send_word(7'h22, 7, 1'b0, 1'b0);
      chk("t6_queued_head", {19'd0, PIX_COL, PIX_DATA}, exp_e(9, 'h21));
      repeat (3) dot(1'b1, 1'b1, 1'b0, 1'b0);
      reset = 1'b1;
      @(negedge CLK_14M);
      reset = 1'b0;
      chk("t6_valid", 32'(PIX_VALID), 32'd0);
      chk("t6_data",  32'(PIX_DATA),  32'd0);
      chk("t6_ovf",   32'(OVF),       32'd0);
      chk("t6_biterr", 32'(BITERR),   32'd0);
      PIX_READY = 1'b1;
      send_word(7'h05, 7, 1'b0, 1'b0);
      chk("t6_arm_no_push", 32'(PIX_VALID), 32'd0);
      send_word(7'h6C, 7, 1'b0, 1'b0);
      chk("t6_head", {19'd0, PIX_COL, PIX_DATA}, exp_e(0, 'h6C));
      idle(4);
      chk("t6_count", 32'(cap_q.size()), 32'd1);
      chk("t6_w0", ent(0), exp_e(0, 'h6C));

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule
